apb_rr_master_arbiter: RTL

//  Shares one APB master port among NUM_REQ on-chip requesters (traffic generators, DMA, CPU bridge).

---
 rtl/apb_rr_master_arbiter_pkg.sv | 29 ++
 rtl/apb_rr_master_arbiter_arb.sv | 55 +++++
 rtl/apb_rr_master_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/apb_rr_master_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// apb_rr_master_arbiter_pkg
//   Shared definitions for the round-robin APB master arbiter:
//   - APB transfer FSM state encoding (IDLE / SETUP / ACCESS)
//   - default APB widths and the constant pprot value
//   - helper that sizes the watchdog counter from the TIMEOUT parameter
// -----------------------------------------------------------------------------
package apb_rr_master_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  localparam int         APB_ADDR_W    = 32;
  localparam int         APB_DATA_W    = 32;
  localparam logic [2:0] PPROT_DEFAULT = 3'b000;

  // Width of a counter that must hold values 0..timeout (at least one bit).
  function automatic int wd_cnt_width(input int timeout);
    if (timeout < 2) begin
      return 1;
    end else begin
      return $clog2(timeout + 1);
    end
  endfunction

endpackage

// File: rtl/apb_rr_master_arbiter_arb.sv
// -----------------------------------------------------------------------------
// apb_rr_arbiter
//   Purely combinational round-robin picker. Searches req_valid starting at
//   rr_ptr and wrapping upward; the first set bit wins.
// Ports
//   req_valid  in   NUM_REQ  per-requester valid
//   rr_ptr     in   IDX_W    highest-priority requester for this search
//   grant_oh   out  NUM_REQ  one-hot grant (all zero when nothing valid)
//   grant_idx  out  IDX_W    index of the granted requester
//   grant_any  out  1        some requester is valid
// -----------------------------------------------------------------------------
module apb_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Rotating priority search; sum is one bit wider so the wrap is a single subtract.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end else begin
        sum = sum;
      end
      cand = sum[IDX_W-1:0];
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end else begin
        grant_any = grant_any;
      end
    end
    if (grant_any) begin
      grant_oh[grant_idx] = 1'b1;
    end else begin
      grant_oh = '0;
    end
  end

endmodule

// File: rtl/apb_rr_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_rr_master_arbiter
//   Shares one APB master port among NUM_REQ requesters. A round-robin pick in
//   IDLE accepts one command, which is run as a SETUP/ACCESS transfer; the
//   result comes back as a one-cycle rsp_valid pulse to the originator. A
//   watchdog ends ACCESS with an error if pready never arrives.
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   req_valid/ready/write           per-requester handshake and direction
//   req_addr/wdata/strb             packed per-requester command fields
//   rsp_valid                       per-requester response pulse
//   rsp_rdata, rsp_err              shared response payload
//   psel, penable, pwrite, paddr,
//   pwdata, pstrb, pprot            APB master outputs
//   prdata, pready, pslverr         APB slave returns
// -----------------------------------------------------------------------------
module apb_rr_master_arbiter
  import apb_rr_master_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_strb,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [ADDR_W-1:0]          paddr,
  output logic [DATA_W-1:0]          pwdata,
  output logic [DATA_W/8-1:0]        pstrb,
  output logic [2:0]                 pprot,
  input  logic [DATA_W-1:0]          prdata,
  input  logic                       pready,
  input  logic                       pslverr
);

  localparam int STRB_W    = DATA_W / 8;
  localparam int IDX_W     = $clog2(NUM_REQ);
  localparam int CNT_W     = wd_cnt_width(TIMEOUT);
  localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
  localparam logic             WD_EN   = (TIMEOUT > 0) ? 1'b1 : 1'b0;

  apb_state_t         state;
  apb_state_t         state_next;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic               grant_any;
  logic [CNT_W-1:0]   wd_cnt;
  logic               accept;
  logic               finish;
  logic               timed_out;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; accept/finish/timed_out qualify the datapath updates.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    timed_out  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_any) begin
          accept     = 1'b1;
          state_next = ST_SETUP;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          finish     = 1'b1;
          state_next = ST_IDLE;
        end else if (WD_EN && (wd_cnt == TO_LAST)) begin
          // This is the TIMEOUT-th stalled ACCESS cycle.
          finish     = 1'b1;
          timed_out  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_ACCESS;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Ready is only offered to the granted requester during IDLE.
  always_comb begin
    if (accept) begin
      req_ready = grant_oh;
    end else begin
      req_ready = '0;
    end
  end

  assign psel    = (state != ST_IDLE);
  assign penable = (state == ST_ACCESS);
  assign pprot   = PPROT_DEFAULT;

  // Command latch and round-robin pointer; APB fields hold while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
      pstrb  <= '0;
      owner  <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      pwrite <= req_write[grant_idx];
      paddr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
      pwdata <= req_wdata[grant_idx*DATA_W +: DATA_W];
      pstrb  <= req_strb[grant_idx*STRB_W +: STRB_W];
      owner  <= grant_idx;
      rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end else begin
      pwrite <= pwrite;
      paddr  <= paddr;
      pwdata <= pwdata;
      pstrb  <= pstrb;
      owner  <= owner;
      rr_ptr <= rr_ptr;
    end
  end

  // Watchdog: counts stalled ACCESS cycles, cleared when a command enters SETUP.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (accept) begin
      wd_cnt <= '0;
    end else if ((state == ST_ACCESS) && !pready && !finish) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end else begin
      wd_cnt <= wd_cnt;
    end
  end

  // Response registers: one-cycle pulse to the owner, payload held until next end.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (finish) begin
      rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
      rsp_rdata <= (timed_out || pwrite) ? '0 : prdata;
      rsp_err   <= timed_out ? 1'b1 : pslverr;
    end else begin
      rsp_valid <= '0;
      rsp_rdata <= rsp_rdata;
      rsp_err   <= rsp_err;
    end
  end

endmodule
